iir_settle_monitor: RTL and testbench
=====================================

# iir_settle_monitor

Consumer of the filtered sample stream produced by the `iir_lowpass_pow2k_filter` chain in the theremin sensor path. On every CE sample it compares the new value with the previous one and classifies the stream as moving or steady. It reports step events, the settled value and the settle time in samples, so downstream pitch/volume logic acts only on stable readings.

## Interface
Parameters:
- `DATA_BITS`, 30, width of `IN_VALUE` and `SETTLED_VALUE`.
- `SIGNED_DATA`, 0, 1 means `IN_VALUE` is two's complement; 0 means unsigned.
- `HOLD_BITS`, 8, width of `HOLD_CYCLES`.
- `TIME_BITS`, 16, width of `SETTLE_TIME`.

Ports:
- `CLK` input 1: single clock; all logic on its rising edge.
- `RESET` input 1: asynchronous, active-low reset.
- `CE` input 1: sample-valid strobe; one sample per cycle where CE=1.
- `IN_VALUE` input `DATA_BITS`: filtered sample.
- `THRESHOLD` input `DATA_BITS`: unsigned tolerance on |delta|.
- `HOLD_CYCLES` input `HOLD_BITS`: consecutive in-tolerance samples required to settle. 0 is treated as 1.
- `SETTLED` output 1: level, high while in SETTLED.
- `SETTLED_STROBE` output 1: one-cycle pulse on entry to SETTLED.
- `STEP_STROBE` output 1: one-cycle pulse when a step is detected.
- `SETTLED_VALUE` output `DATA_BITS`: sample latched at settle.
- `SETTLE_TIME` output `TIME_BITS`: samples from last step or first sample to settle.

## Operation
- delta = IN_VALUE − prev, computed at `DATA_BITS+1` bits (sign- or zero-extended per `SIGNED_DATA`). |delta| is compared unsigned against `THRESHOLD`.
- "In-tolerance" means |delta| ≤ THRESHOLD; equality counts as in-tolerance.
- prev updates on every CE sample.
- IDLE (after reset): first CE sample stores prev, clears hold_cnt and time_cnt, and moves to HOLDING. No strobe is produced.
- HOLDING, in-tolerance sample: hold_cnt+1 and time_cnt+1. If hold_cnt+1 ≥ max(HOLD_CYCLES,1), go to SETTLED: pulse `SETTLED_STROBE`, latch `SETTLED_VALUE`=IN_VALUE and `SETTLE_TIME`=time_cnt+1.
- HOLDING, out-of-tolerance sample: go to MOVING, pulse `STEP_STROBE`, hold_cnt=0, time_cnt=0.
- MOVING, in-tolerance sample: go to HOLDING with hold_cnt=1 and time_cnt+1. Settles immediately if HOLD_CYCLES ≤ 1.
- MOVING, out-of-tolerance sample: stay in MOVING, time_cnt=0, pulse `STEP_STROBE` again.
- SETTLED, in-tolerance sample: stay; outputs unchanged.
- SETTLED, out-of-tolerance sample: go to MOVING, `SETTLED`=0, pulse `STEP_STROBE`, clear counters.
- time_cnt saturates at all-ones. hold_cnt saturates.
- `HOLD_CYCLES` and `THRESHOLD` are sampled live each CE; changing them mid-hold applies from the next sample.
- CE=0: state, counters and prev frozen; strobes stay 0.

## Timing
- All outputs registered. Response appears on the first rising edge after the CE sample edge (latency 1 cycle).
- Strobes are exactly 1 cycle wide, even with CE held high continuously.
- Reset values: `SETTLED`=0, both strobes 0, `SETTLED_VALUE`=0, `SETTLE_TIME`=0; state IDLE, prev=0.
- `RESET` low mid-operation clears everything immediately, without waiting for a clock. The first sample after release is treated as an IDLE sample.
- `SETTLED_STROBE` and `STEP_STROBE` never assert in the same cycle.

## Configuration
- `IIR_SETTLE_MONITOR_TIME_EN` defined: time_cnt and the `SETTLE_TIME` register are built as described above.
- Not defined: no counter is instantiated, `SETTLE_TIME` is constant 0, and all other behaviour is identical.

## Test plan
Parameters for all scenarios: THRESHOLD=100, HOLD_CYCLES=4, macro defined unless stated.
- Reset, no CE: all outputs 0. Assert RESET low mid-hold: outputs clear immediately, without waiting for a clock.
- IN_VALUE=1000 for 10 CE samples: `SETTLED_STROBE` one cycle after sample 5. `SETTLED_VALUE`=1000, `SETTLE_TIME`=4, no `STEP_STROBE`.
- Settled at 1000, step to 2000 and hold: `STEP_STROBE` after the 2000 sample. `SETTLED` drops. Re-settles after 4 more samples with `SETTLED_VALUE`=2000, `SETTLE_TIME`=4.
- Ramp +150/sample for 20 samples: `STEP_STROBE` every sample, never settles. Ramp +100/sample: settles after 4 samples (equality boundary).
- SIGNED_DATA=1, settled at −1000, step to +1000: `STEP_STROBE` fires (|delta|=2000). Settles at `SETTLED_VALUE`=+1000. Unsigned build with 0x3FFFFFFF→0 also fires a step (no wrap).
- HOLD_CYCLES=0: settles on the first in-tolerance sample. CE held low 50 cycles mid-hold: no state change. Macro undefined: `SETTLE_TIME` always 0.

Source files
------------

// File: rtl/iir_settle_monitor.sv
// Settle/step classifier for the filtered theremin sample stream.
// Optional settle-time counter: define IIR_SETTLE_MONITOR_TIME_EN to build it.
module iir_settle_monitor #(
  parameter int DATA_BITS   = 30,
  parameter int SIGNED_DATA = 0,
  parameter int HOLD_BITS   = 8,
  parameter int TIME_BITS   = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 CE,
  input  logic [DATA_BITS-1:0] IN_VALUE,
  input  logic [DATA_BITS-1:0] THRESHOLD,
  input  logic [HOLD_BITS-1:0] HOLD_CYCLES,
  output logic                 SETTLED,
  output logic                 SETTLED_STROBE,
  output logic                 STEP_STROBE,
  output logic [DATA_BITS-1:0] SETTLED_VALUE,
  output logic [TIME_BITS-1:0] SETTLE_TIME
);

  // state   | meaning
  // S_IDLE  | no sample seen since reset; next sample only seeds prev
  // S_HOLD  | counting consecutive in-tolerance samples
  // S_MOVE  | last sample was out of tolerance (step seen)
  // S_SETL  | stream settled; SETTLED_VALUE/SETTLE_TIME latched
  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_MOVE, S_SETL} state_t;

  state_t               state;
  logic [DATA_BITS-1:0] prev;
  logic [HOLD_BITS-1:0] hold_cnt;
  logic [HOLD_BITS-1:0] hold_inc;
  logic [HOLD_BITS-1:0] hold_target;
  logic [DATA_BITS:0]   delta;
  logic [DATA_BITS:0]   abs_delta;
  logic                 in_ext;
  logic                 prev_ext;
  logic                 in_tol;
  logic                 settle_hit;

  // One extra bit keeps the difference exact for both signed and unsigned data.
  assign in_ext      = (SIGNED_DATA != 0) && IN_VALUE[DATA_BITS-1];
  assign prev_ext    = (SIGNED_DATA != 0) && prev[DATA_BITS-1];
  assign delta       = {in_ext, IN_VALUE} - {prev_ext, prev};
  assign abs_delta   = delta[DATA_BITS] ? -delta : delta;
  assign in_tol      = abs_delta <= {1'b0, THRESHOLD};
  assign hold_target = (HOLD_CYCLES == '0) ? HOLD_BITS'(1) : HOLD_CYCLES;
  assign hold_inc    = (hold_cnt == '1) ? hold_cnt : hold_cnt + HOLD_BITS'(1);
  assign settle_hit  = in_tol && (hold_inc >= hold_target);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state          <= S_IDLE;
      prev           <= '0;
      hold_cnt       <= '0;
      SETTLED        <= 1'b0;
      SETTLED_STROBE <= 1'b0;
      STEP_STROBE    <= 1'b0;
      SETTLED_VALUE  <= '0;
    end else begin
      SETTLED_STROBE <= 1'b0;
      STEP_STROBE    <= 1'b0;
      if (CE) begin
        prev <= IN_VALUE;
        case (state)
          S_IDLE: begin
            state    <= S_HOLD;
            hold_cnt <= '0;
          end
          // hold_cnt is zero in S_MOVE, so both states share the hold path
          S_HOLD, S_MOVE: begin
            if (in_tol) begin
              hold_cnt <= hold_inc;
              if (settle_hit) begin
                state          <= S_SETL;
                SETTLED        <= 1'b1;
                SETTLED_STROBE <= 1'b1;
                SETTLED_VALUE  <= IN_VALUE;
              end else begin
                state <= S_HOLD;
              end
            end else begin
              state       <= S_MOVE;
              STEP_STROBE <= 1'b1;
              hold_cnt    <= '0;
            end
          end
          S_SETL: begin
            if (!in_tol) begin
              state       <= S_MOVE;
              SETTLED     <= 1'b0;
              STEP_STROBE <= 1'b1;
              hold_cnt    <= '0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef IIR_SETTLE_MONITOR_TIME_EN
  logic [TIME_BITS-1:0] time_cnt;
  logic [TIME_BITS-1:0] time_inc;

  assign time_inc = (time_cnt == '1) ? time_cnt : time_cnt + TIME_BITS'(1);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      time_cnt    <= '0;
      SETTLE_TIME <= '0;
    end else if (CE) begin
      case (state)
        S_IDLE: time_cnt <= '0;
        S_HOLD, S_MOVE: begin
          if (in_tol) begin
            time_cnt <= time_inc;
            if (settle_hit) SETTLE_TIME <= time_inc;
          end else begin
            time_cnt <= '0;
          end
        end
        S_SETL: if (!in_tol) time_cnt <= '0;
        default: time_cnt <= '0;
      endcase
    end
  end
`else
  assign SETTLE_TIME = '0;
`endif

endmodule

// File: tb/tb_iir_settle_monitor.sv
// Directed bench for iir_settle_monitor: unsigned instance plus a signed instance on shared inputs.
module tb_iir_settle_monitor;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        CE = 1'b0;
  logic [29:0] in_value = '0;
  logic [29:0] threshold = 30'd100;
  logic [7:0]  hold_cycles = 8'd4;

  logic        settled, settled_strobe, step_strobe;
  logic [29:0] settled_value;
  logic [15:0] settle_time;
  logic        s_settled, s_settled_strobe, s_step_strobe;
  logic [29:0] s_settled_value;
  logic [15:0] s_settle_time;

  int total = 0;
  int bad   = 0;

`ifdef IIR_SETTLE_MONITOR_TIME_EN
  localparam bit TIME_EN = 1'b1;
`else
  localparam bit TIME_EN = 1'b0;
`endif

  iir_settle_monitor #(.DATA_BITS(30), .SIGNED_DATA(0), .HOLD_BITS(8), .TIME_BITS(16)) u_dut (
    .CLK(CLK), .RESET(RESET), .CE(CE), .IN_VALUE(in_value), .THRESHOLD(threshold),
    .HOLD_CYCLES(hold_cycles), .SETTLED(settled), .SETTLED_STROBE(settled_strobe),
    .STEP_STROBE(step_strobe), .SETTLED_VALUE(settled_value), .SETTLE_TIME(settle_time)
  );

  iir_settle_monitor #(.DATA_BITS(30), .SIGNED_DATA(1), .HOLD_BITS(8), .TIME_BITS(16)) u_dut_s (
    .CLK(CLK), .RESET(RESET), .CE(CE), .IN_VALUE(in_value), .THRESHOLD(threshold),
    .HOLD_CYCLES(hold_cycles), .SETTLED(s_settled), .SETTLED_STROBE(s_settled_strobe),
    .STEP_STROBE(s_step_strobe), .SETTLED_VALUE(s_settled_value), .SETTLE_TIME(s_settle_time)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] exp_time(input int t);
    return TIME_EN ? 32'(t) : 32'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic smp(input logic [29:0] v);
    CE = 1'b1;
    in_value = v;
    @(posedge CLK);
    #1;
  endtask

  task automatic smp_chk(input string tag, input logic [29:0] v, input bit e_step, input bit e_set);
    smp(v);
    check({tag, "_step"}, 32'(step_strobe), 32'(e_step));
    check({tag, "_sst"}, 32'(settled_strobe), 32'(e_set));
  endtask

  initial begin
    int quiet;

    // reset with no CE
    repeat (3) @(posedge CLK);
    #1;
    check("rst_settled", 32'(settled), 0);
    check("rst_sst", 32'(settled_strobe), 0);
    check("rst_step", 32'(step_strobe), 0);
    check("rst_value", 32'(settled_value), 0);
    check("rst_time", 32'(settle_time), 0);
    check("rst_s_settled", 32'(s_settled), 0);
    @(negedge CLK);
    RESET = 1'b1;

    // constant input settles after the seed sample plus four holds
    for (int i = 1; i <= 10; i++) smp_chk("const", 30'd1000, 1'b0, i == 5);
    check("const_settled", 32'(settled), 1);
    check("const_value", 32'(settled_value), 1000);
    check("const_time", 32'(settle_time), exp_time(4));

    // step and re-settle
    smp_chk("step", 30'd2000, 1'b1, 1'b0);
    check("step_settled_drop", 32'(settled), 0);
    for (int i = 1; i <= 4; i++) smp_chk("resettle", 30'd2000, 1'b0, i == 4);
    check("resettle_value", 32'(settled_value), 2000);
    check("resettle_time", 32'(settle_time), exp_time(4));

    // ramps just above and exactly at threshold
    for (int i = 1; i <= 20; i++) smp_chk("ramp150", 30'(2000 + 150 * i), 1'b1, 1'b0);
    check("ramp150_settled", 32'(settled), 0);
    for (int i = 1; i <= 4; i++) smp_chk("ramp100", 30'(5000 + 100 * i), 1'b0, i == 4);
    check("ramp100_value", 32'(settled_value), 5400);
    check("ramp100_time", 32'(settle_time), exp_time(4));

    // HOLD_CYCLES=0 behaves as 1
    hold_cycles = 8'd0;
    smp_chk("h0_step", 30'd7000, 1'b1, 1'b0);
    smp_chk("h0_set", 30'd7000, 1'b0, 1'b1);
    check("h0_value", 32'(settled_value), 7000);
    check("h0_time", 32'(settle_time), exp_time(1));
    hold_cycles = 8'd4;

    // CE low mid-hold freezes everything
    smp_chk("ce_step", 30'd9000, 1'b1, 1'b0);
    smp_chk("ce_hold1", 30'd9000, 1'b0, 1'b0);
    smp_chk("ce_hold2", 30'd9000, 1'b0, 1'b0);
    CE = 1'b0;
    in_value = 30'd20000;
    quiet = 0;
    repeat (50) begin
      @(posedge CLK);
      #1;
      if (settled_strobe || step_strobe || settled) quiet++;
    end
    check("ce_low_quiet", 32'(quiet), 0);
    smp_chk("ce_hold3", 30'd9000, 1'b0, 1'b0);
    smp_chk("ce_settle", 30'd9000, 1'b0, 1'b1);
    check("ce_time", 32'(settle_time), exp_time(4));

    // unsigned max to zero is a real step, not a wrap
    smp_chk("wrap_a", 30'h3FFFFFFF, 1'b1, 1'b0);
    smp_chk("wrap_b", 30'h3FFFFFFF, 1'b0, 1'b0);
    smp_chk("wrap_zero", 30'd0, 1'b1, 1'b0);

    // signed instance: settle at -1000, step to +1000
    smp(30'h3FFFFC18);
    check("s_neg_step", 32'(s_step_strobe), 1);
    for (int i = 1; i <= 4; i++) begin
      smp(30'h3FFFFC18);
      check("s_neg_sst", 32'(s_settled_strobe), 32'(i == 4));
    end
    check("s_neg_value", 32'(s_settled_value), 32'h3FFFFC18);
    smp(30'd1000);
    check("s_pos_step", 32'(s_step_strobe), 1);
    check("s_pos_drop", 32'(s_settled), 0);
    for (int i = 1; i <= 4; i++) begin
      smp(30'd1000);
      check("s_pos_sst", 32'(s_settled_strobe), 32'(i == 4));
      check("s_pos_nostep", 32'(s_step_strobe), 0);
    end
    check("s_pos_value", 32'(s_settled_value), 1000);
    check("s_pos_time", 32'(s_settle_time), exp_time(4));

    // asynchronous reset mid-hold
    smp_chk("pre_rst_step", 30'd3000, 1'b1, 1'b0);
    smp_chk("pre_rst_hold", 30'd3000, 1'b0, 1'b0);
    check("pre_rst_value", 32'(settled_value), 1000);
    #2;
    RESET = 1'b0;
    #1;
    check("async_rst_value", 32'(settled_value), 0);
    check("async_rst_time", 32'(settle_time), 0);
    check("async_rst_settled", 32'(settled), 0);
    check("async_rst_s_value", 32'(s_settled_value), 0);
    CE = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    for (int i = 1; i <= 5; i++) smp_chk("post_rst", 30'd3000, 1'b0, i == 5);
    check("post_rst_value", 32'(settled_value), 3000);
    check("post_rst_time", 32'(settle_time), exp_time(4));
    CE = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
